fb_line_fetcher: RTL and testbench

- Prefetch stage that sits between the shared 32K x 16 video/CPU RAM and the pixel output.
- Streams 2-bpp framebuffer words into a small FIFO during both active video and blanking, using a hold/ack handshake that stalls the CPU only while it owns the bus.
- Serialises each word into eight pixels through a 4-entry programmable palette.
- Replaces direct combinational RAM reads in the video path with an arbitrated, buffered fetch.

---
 rtl/fb_line_fetcher.sv | 133 +++++++++++++
 tb/tb_fb_line_fetcher.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_line_fetcher.sv
// Framebuffer prefetch: arbitrated word fetch into a small FIFO, then 2-bpp
// serialisation through a 4-entry palette to a registered rgb output.
module fb_line_fetcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [14:0] BASE_ADDR  = 15'h4000,
    parameter logic [15:0] PAL_INIT   = 16'h7410
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        display_on,
    input  logic [8:0]  hpos,
    input  logic        vsync,
    output logic        mem_req,
    output logic [14:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    input  logic        pal_we,
    input  logic [1:0]  pal_idx,
    input  logic [3:0]  pal_data,
    output logic [3:0]  rgb,
    output logic        underflow,
    input  logic        status_clr
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state;
    logic [12:0]      fetch_idx;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       palette [4];
    logic [15:0]      shifter;

    logic        fifo_empty_c;
    logic        load_c;
    logic        push_c;
    logic        pop_c;
    logic        uf_set_c;
    logic [15:0] load_word_c;
    logic [15:0] shift_word_c;
    logic [1:0]  pix_c;
    logic        hpos_unused_c;

    // Only the pixel-within-word bits of hpos matter here.
    assign hpos_unused_c = ^hpos[8:3];

    always_comb begin
        fifo_empty_c = (count == '0);
        load_c       = display_on && (hpos[2:0] == 3'd0);
        pop_c        = load_c && !fifo_empty_c;
        uf_set_c     = load_c && fifo_empty_c;
        push_c       = (state == REQ) && mem_ack && !vsync;
        load_word_c  = fifo_empty_c ? 16'h0000 : fifo_mem[rd_ptr];
        shift_word_c = {shifter[13:0], 2'b00};
        pix_c        = load_c ? load_word_c[15:14] : shifter[13:12];
    end

    // Fetch FSM: one outstanding request; vsync flushes and rewinds to the frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= BASE_ADDR;
            fetch_idx <= '0;
        end else if (vsync) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            fetch_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count < CNT_W'(FIFO_DEPTH)) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= BASE_ADDR + 15'(fetch_idx);
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        fetch_idx <= fetch_idx + 13'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (vsync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    // Pixel serialiser, palette and sticky underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shifter   <= '0;
            rgb       <= 4'h0;
            underflow <= 1'b0;
            for (int i = 0; i < 4; i++) palette[i] <= PAL_INIT[4*i +: 4];
        end else begin
            if (display_on) begin
                shifter <= load_c ? load_word_c : shift_word_c;
                rgb     <= palette[pix_c];
            end else begin
                rgb <= 4'h0;
            end
            if (uf_set_c)        underflow <= 1'b1;
            else if (status_clr) underflow <= 1'b0;
            if (pal_we) palette[pal_idx] <= pal_data;
        end
    end
endmodule

// File: tb/tb_fb_line_fetcher.sv
// Self-checking bench for fb_line_fetcher: directed scenarios plus random
// traffic compared every cycle against a word/pixel-level reference model.
module tb_fb_line_fetcher;
    localparam int unsigned DEPTH = 4;
    localparam logic [14:0] BASE  = 15'h4000;
    localparam logic [15:0] PAL0  = 16'h7410;

    logic        clk = 1'b0;
    logic        reset, display_on, vsync, mem_ack, pal_we, status_clr;
    logic [8:0]  hpos;
    logic [1:0]  pal_idx;
    logic [3:0]  pal_data;
    logic [15:0] mem_data;
    logic        mem_req, underflow;
    logic [14:0] mem_addr;
    logic [3:0]  rgb;
    logic [15:0] ram [64];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_q [$];
    logic [3:0]  m_pal [4];
    int          m_idx;
    logic        m_req;
    logic [14:0] m_addr;
    logic [15:0] m_word;
    int          m_nsh;
    logic [3:0]  m_rgb;
    logic        m_uf;

    always #5 clk = ~clk;
    assign mem_data = ram[mem_addr[5:0]];

    fb_line_fetcher dut (
        .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos),
        .vsync(vsync), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_data(pal_data), .rgb(rgb),
        .underflow(underflow), .status_clr(status_clr)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_pal[i] = PAL0[4*i +: 4];
        m_idx  = 0;
        m_req  = 1'b0;
        m_addr = BASE;
        m_word = 16'h0;
        m_nsh  = 0;
        m_rgb  = 4'h0;
        m_uf   = 1'b0;
    endtask

    // One clock of the spec's rules, using the inputs held across this edge.
    task automatic model_edge();
        int          cnt;
        logic [15:0] w;
        logic [1:0]  code;
        logic        uf_set;
        cnt    = m_q.size();
        uf_set = 1'b0;
        if (display_on) begin
            if (hpos[2:0] == 3'd0) begin
                if (cnt > 0) w = m_q.pop_front();
                else begin
                    w      = 16'h0;
                    uf_set = 1'b1;
                end
                m_word = w;
                m_nsh  = 0;
            end else begin
                m_nsh++;
            end
            code  = (m_nsh < 8) ? 2'((m_word >> (14 - 2*m_nsh)) & 16'h3) : 2'b00;
            m_rgb = m_pal[code];
        end else begin
            m_rgb = 4'h0;
        end
        if (uf_set)          m_uf = 1'b1;
        else if (status_clr) m_uf = 1'b0;
        if (pal_we) m_pal[pal_idx] = pal_data;
        if (vsync) begin
            m_q.delete();
            m_idx = 0;
            m_req = 1'b0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_q.push_back(ram[m_addr[5:0]]);
                m_idx = (m_idx + 1) % 8192;
                m_req = 1'b0;
            end
        end else if (cnt < DEPTH) begin
            m_req  = 1'b1;
            m_addr = 15'((int'(BASE) + m_idx) % 32768);
        end
    endtask

    task automatic check_all();
        chk("mem_req",   16'(mem_req),   16'(m_req));
        chk("mem_addr",  16'(mem_addr),  16'(m_addr));
        chk("rgb",       16'(rgb),       16'(m_rgb));
        chk("underflow", 16'(underflow), 16'(m_uf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [3:0] exp_a [8];
        logic [3:0] exp_b [8];
        exp_a = '{4'h0, 4'h1, 4'h4, 4'h7, 4'h0, 4'h1, 4'h4, 4'h7};
        exp_b = '{4'h0, 4'h1, 4'hF, 4'h7, 4'h0, 4'h1, 4'hF, 4'h7};
        for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
        ram[0] = 16'h1B1B;

        reset = 1'b0; display_on = 1'b0; hpos = 9'd0; vsync = 1'b0;
        mem_ack = 1'b1; pal_we = 1'b0; pal_idx = 2'd0; pal_data = 4'h0;
        status_clr = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // Free-running fetch with ack tied high: alternate req, addresses 4000..4003
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("seq_req", 16'(mem_req), (i < 8 && i % 2 == 0) ? 16'd1 : 16'd0);
            if (i < 8 && i % 2 == 0) chk("seq_addr", 16'(mem_addr), 16'(16'h4000 + i / 2));
        end

        // First word 1B1B through the reset palette
        display_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hpos = 9'(i);
            tick();
            chk("rgb_1b1b", 16'(rgb), 16'(exp_a[i]));
        end

        // Starve the FIFO during active video
        mem_ack = 1'b0;
        for (int i = 8; i < 56; i++) begin
            hpos = 9'(i);
            tick();
        end
        chk("uf_set", 16'(underflow), 16'd1);
        display_on = 1'b0; status_clr = 1'b1;
        tick();
        chk("uf_clr", 16'(underflow), 16'd0);
        status_clr = 1'b0;

        // vsync coinciding with an ack drops the word and rewinds the address
        chk("req_before_vsync", 16'(mem_req), 16'd1);
        vsync = 1'b1; mem_ack = 1'b1;
        tick();
        chk("req_in_vsync", 16'(mem_req), 16'd0);
        vsync = 1'b0; mem_ack = 1'b0;
        tick();
        chk("addr_after_vsync", 16'(mem_addr), 16'h4000);
        display_on = 1'b1; hpos = 9'd0;
        tick();
        chk("vsync_discard_uf", 16'(underflow), 16'd1);

        // Refill, then rewrite palette entry 2 mid-line
        display_on = 1'b0; status_clr = 1'b1; mem_ack = 1'b1;
        tick();
        status_clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        display_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hpos = 9'(i);
            pal_we = (i == 1); pal_idx = 2'd2; pal_data = 4'hF;
            tick();
            chk("rgb_palwr", 16'(rgb), 16'(exp_b[i]));
        end
        pal_we = 1'b0;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            display_on = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) hpos = 9'($urandom);
            else hpos = hpos + 9'd1;
            mem_ack    = ($urandom_range(0, 3) != 0);
            vsync      = ($urandom_range(0, 49) == 0);
            pal_we     = ($urandom_range(0, 19) == 0);
            pal_idx    = 2'($urandom);
            pal_data   = 4'($urandom);
            status_clr = ($urandom_range(0, 9) == 0);
            tick();
        end

        // Asynchronous reset in the middle of an outstanding request
        vsync = 1'b0; pal_we = 1'b0; status_clr = 1'b0; mem_ack = 1'b0;
        display_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            hpos = hpos + 9'd1;
            tick();
            if (m_req) break;
        end
        chk("req_before_reset", 16'(mem_req), 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("reset_req", 16'(mem_req), 16'd0);
        chk("reset_rgb", 16'(rgb), 16'd0);
        chk("reset_uf", 16'(underflow), 16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1; display_on = 1'b0; mem_ack = 1'b1;
        check_all();
        tick();
        chk("req_after_reset", 16'(mem_req), 16'd1);
        chk("addr_after_reset", 16'(mem_addr), 16'h4000);
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
